// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall/flush controller for the 5-stage core, sitting beside ID.
// Stalls ID when an operand cannot be forwarded in time (load-use, or a
// branch resolved in ID that depends on an EX result or a load in MEM),
// freezes the pipe on D-cache misses, and holds a taken-branch redirect
// pending across an I-cache miss so the wrong-path fetch can drain first.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   IF_ID_rs1/rs2, IF_ID_use_rs*   sources of the ID instruction
//   IF_ID_branch, branch_taken     branch in ID and its redirect decision
//   ID_EX_rd/memread/regwrite      destination and control of EX
//   EX_MEM_rd/memread              destination and load flag of MEM
//   ICACHE_stall, DCACHE_stall     cache busy
//   PC_write, IF_ID_write          front-end enables
//   IF_ID_flush, ID_EX_bubble      IF/ID clear, NOP insert into ID/EX
//   pipe_en                        enable for ID/EX, EX/MEM, MEM/WB
//   tgt_latch_en, pc_sel_pend      redirect-target latch and PC mux select
//   redirect_pending               registered pend flag
//   bubble_cnt, dfreeze_cnt,
//   redirect_cnt                   saturating performance counters
//
// state | meaning
// RUN   | no cache miss in the last cycle
// IWAIT | last cycle saw an I-cache miss (no D-cache miss)
// DWAIT | last cycle saw a D-cache miss
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic             IF_ID_branch,
  input  logic             branch_taken,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_memread,
  input  logic             ID_EX_regwrite,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_memread,
  input  logic             ICACHE_stall,
  input  logic             DCACHE_stall,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             pipe_en,
  output logic             tgt_latch_en,
  output logic             pc_sel_pend,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] dfreeze_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {RUN, IWAIT, DWAIT} state_e;

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] bub_q, bub_d;
  logic [CNT_W-1:0] dfr_q, dfr_d;
  logic [CNT_W-1:0] red_q, red_d;
  logic             bub_inc, dfr_inc, red_inc;

  logic ex_hit, mem_hit, load_use, br_dep, hazard;

  // x0 never creates a dependency; an unused source field is don't-care.
  function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic use1,
                                   input logic use2);
    return (rd != 5'd0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
  endfunction

  always_comb begin
    ex_hit   = src_hit(ID_EX_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2);
    mem_hit  = src_hit(EX_MEM_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2);
    load_use = ID_EX_memread && ex_hit;
    br_dep   = IF_ID_branch && ((ID_EX_regwrite && ex_hit) || (EX_MEM_memread && mem_hit));
    hazard   = load_use || br_dep;
  end

  always_comb begin
    if (DCACHE_stall)      state_d = DWAIT;
    else if (ICACHE_stall) state_d = IWAIT;
    else                   state_d = RUN;
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    pipe_en      = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    tgt_latch_en = 1'b0;
    pc_sel_pend  = 1'b0;
    pend_d       = pend_q;
    bub_inc      = 1'b0;
    dfr_inc      = 1'b0;
    red_inc      = 1'b0;
    if (rst) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_en     = 1'b0;
      pend_d      = 1'b0;
    end else if (DCACHE_stall) begin
      pipe_en     = 1'b0;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      dfr_inc     = 1'b1;
    end else if (pend_q && !ICACHE_stall) begin
      // Wrong-path fetch has returned: steer PC to the latched target and
      // discard what came back. Already counted when pend was set.
      pc_sel_pend = 1'b1;
      IF_ID_flush = 1'b1;
      pend_d      = 1'b0;
    end else if (hazard) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      bub_inc      = 1'b1;
    end else if (ICACHE_stall) begin
      PC_write    = 1'b0;
      IF_ID_flush = 1'b1;
      if (branch_taken && !pend_q) begin
        tgt_latch_en = 1'b1;
        pend_d       = 1'b1;
        red_inc      = 1'b1;
      end
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
      red_inc     = 1'b1;
    end
  end

  always_comb begin
    bub_d = bub_q;
    dfr_d = dfr_q;
    red_d = red_q;
    if (bub_inc && bub_q != '1) bub_d = bub_q + 1'b1;
    if (dfr_inc && dfr_q != '1) dfr_d = dfr_q + 1'b1;
    if (red_inc && red_q != '1) red_d = red_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      bub_q   <= '0;
      dfr_q   <= '0;
      red_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      bub_q   <= bub_d;
      dfr_q   <= dfr_d;
      red_q   <= red_d;
    end
  end

  // Registered outputs are forced low while reset is held so every output
  // reads 0 during reset, not just after the edge.
  assign redirect_pending = pend_q && !rst;
  assign bubble_cnt       = rst ? '0 : bub_q;
  assign dfreeze_cnt      = rst ? '0 : dfr_q;
  assign redirect_cnt     = rst ? '0 : red_q;

  // The state only tracks which cache held the previous cycle.
  a_state_tracks_dcache : assert property (@(posedge clk) disable iff (rst)
    $past(rst) || ((state_q == DWAIT) == $past(DCACHE_stall)));
  a_state_tracks_icache : assert property (@(posedge clk) disable iff (rst)
    $past(rst) || ((state_q == IWAIT) == ($past(ICACHE_stall) && !$past(DCACHE_stall))));

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int CW = 4;
  localparam logic [CW-1:0] SAT = '1;

  // expected output byte: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
  //                        pipe_en, tgt_latch_en, pc_sel_pend, redirect_pending}
  localparam logic [7:0] O_RST = 8'h00;
  localparam logic [7:0] O_DEF = 8'hC8;
  localparam logic [7:0] O_HAZ = 8'h18;
  localparam logic [7:0] O_BR  = 8'hE8;
  localparam logic [7:0] O_IM  = 8'h68;
  localparam logic [7:0] O_IML = 8'h6C;
  localparam logic [7:0] O_RES = 8'hEA;
  localparam logic [7:0] O_DF  = 8'h00;
  localparam logic [7:0] P     = 8'h01;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2, br, bt;
    logic [4:0] exrd;
    logic       exmr, exrw;
    logic [4:0] memrd;
    logic       memmr, ic, dc;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int            id;
    logic [7:0]    exp;
    logic [CW-1:0] eb, ed, er;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic IF_ID_use_rs1, IF_ID_use_rs2, IF_ID_branch, branch_taken;
  logic ID_EX_memread, ID_EX_regwrite, EX_MEM_memread, ICACHE_stall, DCACHE_stall;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_en;
  logic tgt_latch_en, pc_sel_pend, redirect_pending;
  logic [CW-1:0] bubble_cnt, dfreeze_cnt, redirect_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .IF_ID_branch(IF_ID_branch), .branch_taken(branch_taken),
    .ID_EX_rd(ID_EX_rd), .ID_EX_memread(ID_EX_memread), .ID_EX_regwrite(ID_EX_regwrite),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
    .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .pipe_en(pipe_en), .tgt_latch_en(tgt_latch_en),
    .pc_sel_pend(pc_sel_pend), .redirect_pending(redirect_pending),
    .bubble_cnt(bubble_cnt), .dfreeze_cnt(dfreeze_cnt), .redirect_cnt(redirect_cnt)
  );

  vec_t          vecs[$];
  sb_t           sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] m_bub = '0, m_dfr = '0, m_red = '0;

  function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1,
                              logic u2, logic br, logic bt, logic [4:0] exrd,
                              logic exmr, logic exrw, logic [4:0] memrd, logic memmr,
                              logic ic, logic dc, logic [7:0] exp);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br; v.bt = bt;
    v.exrd = exrd; v.exmr = exmr; v.exrw = exrw; v.memrd = memrd; v.memmr = memmr;
    v.ic = ic; v.dc = dc; v.exp = exp;
    return v;
  endfunction

  function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] c);
    return (c == SAT) ? c : c + 1'b1;
  endfunction

  task automatic apply(input vec_t v);
    sb_t s, g;
    logic [7:0] act;
    @(negedge clk);
    rst = v.rst; IF_ID_rs1 = v.rs1; IF_ID_rs2 = v.rs2;
    IF_ID_use_rs1 = v.u1; IF_ID_use_rs2 = v.u2; IF_ID_branch = v.br; branch_taken = v.bt;
    ID_EX_rd = v.exrd; ID_EX_memread = v.exmr; ID_EX_regwrite = v.exrw;
    EX_MEM_rd = v.memrd; EX_MEM_memread = v.memmr; ICACHE_stall = v.ic; DCACHE_stall = v.dc;
    s.id = n_vec; s.exp = v.exp;
    s.eb = v.rst ? '0 : m_bub; s.ed = v.rst ? '0 : m_dfr; s.er = v.rst ? '0 : m_red;
    sb.push_back(s);
    // counters advance at the coming edge according to the rule that fired
    if (v.rst) begin
      m_bub = '0; m_dfr = '0; m_red = '0;
    end else begin
      if (v.exp[4]) m_bub = sat_inc(m_bub);
      if (!v.exp[3]) m_dfr = sat_inc(m_dfr);
      if (v.exp[2] || (v.exp[5] && v.exp[7] && !v.exp[1])) m_red = sat_inc(m_red);
    end
    #2;
    g = sb.pop_front();
    n_vec++;
    act = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_en,
           tgt_latch_en, pc_sel_pend, redirect_pending};
    if (act !== g.exp) begin
      n_err++;
      $display("FAIL vec%0d outputs {pcw,ifw,flush,bub,pipe,latch,pcsel,pend}: got %b expected %b",
               g.id, act, g.exp);
    end
    if (bubble_cnt !== g.eb) begin
      n_err++;
      $display("FAIL vec%0d bubble_cnt: got %0d expected %0d", g.id, bubble_cnt, g.eb);
    end
    if (dfreeze_cnt !== g.ed) begin
      n_err++;
      $display("FAIL vec%0d dfreeze_cnt: got %0d expected %0d", g.id, dfreeze_cnt, g.ed);
    end
    if (redirect_cnt !== g.er) begin
      n_err++;
      $display("FAIL vec%0d redirect_cnt: got %0d expected %0d", g.id, redirect_cnt, g.er);
    end
  endtask

  initial begin
    //                r  rs1 rs2 u1 u2 br bt exrd mr rw mrd mmr ic dc  exp
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_RST));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF));
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, O_HAZ)); // load-use rs1
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, O_DEF)); // rd = x0
    vecs.push_back(mk(0, 5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, O_DEF)); // source unused
    vecs.push_back(mk(0, 1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, O_HAZ)); // load-use rs2
    vecs.push_back(mk(0, 7, 0, 1, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0, O_HAZ)); // br on ALU in EX
    vecs.push_back(mk(0, 7, 0, 1, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0, O_DEF)); // ALU now in MEM
    vecs.push_back(mk(0, 7, 0, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, O_HAZ)); // br on load in EX
    vecs.push_back(mk(0, 7, 0, 1, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, O_HAZ)); // load now in MEM
    vecs.push_back(mk(0, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF));
    vecs.push_back(mk(0, 7, 0, 1, 0, 1, 1, 7, 0, 1, 0, 0, 0, 0, O_HAZ)); // taken ignored
    vecs.push_back(mk(0, 7, 0, 1, 0, 1, 1, 0, 0, 0, 7, 0, 0, 0, O_BR));  // clean redirect
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, O_IML)); // I-miss cyc 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, O_IM | P));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_IM | P));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RES | P));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, O_IML)); // pend again
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 1, 1, O_DF | P));
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, O_DF | P)); // I released
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, O_DF | P));
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, O_DF | P));
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, O_RES | P)); // redirect first
    vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, O_HAZ));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, O_IML)); // enter IWAIT+pend
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, O_RST)); // reset mid-stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF));
    for (int i = 0; i < 18; i++)
      vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, O_HAZ)); // saturate bubble_cnt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF));

    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: single-cycle I-miss with taken branch, then hazard
    // alongside an I-miss (hazard takes precedence, no latch).
    apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, O_IML));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RES | P));
    apply(mk(0, 9, 0, 1, 0, 1, 1, 9, 1, 1, 0, 0, 1, 0, O_HAZ));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, O_IML));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RES | P));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall/flush controller for the 5-stage RISC-V core. It complements forwarding: the forwarding unit bypasses operands that already exist somewhere in the pipeline, and this block stalls whenever an operand cannot be forwarded in time. It also sequences instruction-cache and data-cache freezes and holds a taken-branch redirect pending across an I-cache miss. It sits beside the ID stage and drives the PC, IF/ID and ID/EX enables.

## Interface
- CNT_W, 32, width of the saturating performance counters
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- IF_ID_rs1, IF_ID_rs2  in  5 each  source registers of the instruction in ID
- IF_ID_use_rs1, IF_ID_use_rs2  in  1 each  the ID instruction reads that source
- IF_ID_branch  in  1  ID instruction is a branch or jalr, resolved in ID
- branch_taken  in  1  ID redirect decision; valid only when no hazard is flagged
- ID_EX_rd  in  5, ID_EX_memread  in  1, ID_EX_regwrite  in  1  destination and control of the instruction in EX
- EX_MEM_rd  in  5, EX_MEM_memread  in  1  destination and load flag of the instruction in MEM
- ICACHE_stall, DCACHE_stall  in  1 each  cache busy
- PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble  out  1 each  front-end enables, IF/ID clear, NOP insert into ID/EX
- pipe_en  out  1  enable for the ID/EX, EX/MEM and MEM/WB registers
- tgt_latch_en  out  1  load the datapath's redirect-target register
- pc_sel_pend  out  1  PC mux selects the latched target
- redirect_pending  out  1  registered pend flag
- bubble_cnt, dfreeze_cnt, redirect_cnt  out  CNT_W each  performance counters

## Operation
A source matches a destination only when the destination is nonzero, equals the source, and the matching IF_ID_use_rsN is set.

Hazard detection (combinational):
- load_use = ID_EX_memread and ID_EX_rd matches an ID source.
- br_dep = IF_ID_branch and one of:
  - ID_EX_regwrite and ID_EX_rd matches an ID source
  - EX_MEM_memread and EX_MEM_rd matches an ID source
- hazard = load_use or br_dep.

State machine with states RUN, IWAIT and DWAIT. The next state is:
- DWAIT if DCACHE_stall
- else IWAIT if ICACHE_stall
- else RUN

The next state is independent of the current state. The state is used for counters and event tracking only.

Output priority, evaluated per cycle. Unlisted outputs default to PC_write=1, IF_ID_write=1, pipe_en=1, everything else 0.
1. rst: all outputs 0. State goes to RUN, pend clears, counters clear.
2. DCACHE_stall: pipe_en=0, PC_write=0, IF_ID_write=0; flush, bubble and latch are 0. pend is held.
3. pend=1 and ICACHE_stall=0 (the wrong-path fetch has returned): PC_write=1, pc_sel_pend=1, IF_ID_flush=1. pend clears. This rule wins over hazard, although ID holds a bubble here so hazard cannot normally be asserted.
4. hazard: PC_write=0, IF_ID_write=0, ID_EX_bubble=1. branch_taken is ignored.
5. ICACHE_stall (pend=0 or 1):
   - PC_write=0, IF_ID_flush=1, so ID receives a bubble.
   - If branch_taken and pend=0: tgt_latch_en=1 and pend sets.
   - A branch_taken seen while pend=1 is ignored.
6. branch_taken: IF_ID_flush=1 (PC_write stays 1).
7. Otherwise the defaults apply.

Counters are saturating and stick at all-ones:
- bubble_cnt: +1 per cycle in which rule 4 fires.
- dfreeze_cnt: +1 per cycle in which DCACHE_stall is high (rule 2).
- redirect_cnt: +1 per redirect, counted on rule 6, or on rule 5 when it sets pend. A redirect completed through rule 3 does not count a second time.

redirect_pending reflects the pend register.

## Timing
- All enables are combinational from the current inputs and the pend register, with zero-cycle latency. The datapath samples them on the next edge.
- pend sets at the edge that ends the rule-5 cycle. It clears at the edge that ends the rule-3 cycle.
- For an I-miss of N cycles with a taken branch in the first cycle:
  - tgt_latch_en is high in cycle 1 only.
  - pc_sel_pend is high in cycle N+1.
  - The correct-path fetch starts in cycle N+2.
- DCACHE_stall arriving in the same cycle the I-cache releases with pend=1: rule 2 wins and the redirect waits for the D-cache.
- br_dep on an EX ALU result stalls for 1 cycle. br_dep on a load in EX stalls for 2 cycles (load_use or br_dep, then the EX_MEM term). These are re-evaluated each cycle with no counter.
- Reset mid-stall, including with pend=1: after the edge, state is RUN, pend=0, and all counters are 0.

## Test plan
- Load to x5 in EX, ID uses rs1=5 -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1, bubble_cnt 0->1. The same case with ID_EX_rd=0 -> no stall.
- Branch in ID with rs1=7:
  - ID_EX_rd=7 and ID_EX_regwrite -> 1 bubble.
  - Load to x7 in EX -> 2 bubbles.
  - EX_MEM non-load rd=7 -> 0 bubbles.
- branch_taken with no hazard and no cache stall -> IF_ID_flush=1, PC_write=1, redirect_cnt=1.
- ICACHE_stall for 3 cycles with branch_taken in cycle 1 -> tgt_latch_en=1 in cycle 1 only, redirect_pending=1 in cycles 2-4, pc_sel_pend=1 and IF_ID_flush=1 in cycle 4, pending=0 in cycle 5, redirect_cnt=1.
- DCACHE_stall for 4 cycles while a load_use hazard is present and pend=1 -> pipe_en=0 and all writes 0 in every cycle, ID_EX_bubble=0, dfreeze_cnt=4, pend retained. Then the hazard bubble and the redirect resolve afterwards.
- rst asserted in IWAIT with pend=1 and counters nonzero -> all outputs 0 during reset, then pend=0, counters 0, RUN. bubble_cnt preset near all-ones must saturate.
